tdm_mux8: RTL and testbench

- Time-division multiplexer: captures one frame of 8 channel words in a single handshake, then emits them one slot per cycle on a single output lane.
- Emits slot 0 first, slot 7 last, with slot index and start-of-frame marker.
- Transmit-side counterpart of the 1-to-8 demux tree: the downstream demux8 takes out_sel as its select and out_data as its input.

---
 rtl/tdm_mux8_pkg.sv | 21 ++
 rtl/tdm_mux8_word.sv | 26 ++
 rtl/tdm_mux8.sv | 122 ++++++++++++
 tb/tb_tdm_mux8.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_mux8_pkg.sv
// Shared constants and state encoding for the TDM transmit mux and its receive-side demux.
// Optional parity slot enabled by defining TDM_PARITY_EN.
package tdm_mux8_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

`ifdef TDM_PARITY_EN
    localparam int NUM_SLOTS = NUM_CH + 1;
    localparam int CNT_W     = 4;
`else
    localparam int NUM_SLOTS = NUM_CH;
    localparam int CNT_W     = 3;
`endif

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_mux8_word.sv
// Combinational 8:1 word selector built as three levels of 2:1 stages,
// mirroring the structure of the receive-side demux tree.
module mux8_word
    import tdm_mux8_pkg::*;
#(
    parameter int CH_W = 8
) (
    input  logic [SEL_W-1:0]       sel,
    input  logic [NUM_CH*CH_W-1:0] words,
    output logic [CH_W-1:0]        word
);

    logic [CH_W-1:0] stage1 [4];
    logic [CH_W-1:0] stage2 [2];

    for (genvar i = 0; i < 4; i++) begin : g_stage1
        assign stage1[i] = sel[0] ? words[(2*i+1)*CH_W +: CH_W] : words[(2*i)*CH_W +: CH_W];
    end

    for (genvar i = 0; i < 2; i++) begin : g_stage2
        assign stage2[i] = sel[1] ? stage1[2*i+1] : stage1[2*i];
    end

    assign word = sel[2] ? stage2[1] : stage2[0];

endmodule

// File: rtl/tdm_mux8.sv
// 8-channel time-division mux: one frame accepted per handshake, one slot emitted per beat.
// Defining TDM_PARITY_EN appends a ninth XOR-parity slot to each frame.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no frame held; in_ready=1, outputs quiet
// ST_SEND | presenting slot cnt_q; reload on accept at the last slot
module tdm_mux8
    import tdm_mux8_pkg::*;
#(
    parameter int CH_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_CH*CH_W-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [CH_W-1:0]        out_data,
    output logic [SEL_W-1:0]       out_sel,
    output logic                   out_sof,
    output logic                   out_par,
    output logic                   out_valid,
    input  logic                   out_ready
);

    state_t                   state_q, state_d;
    logic [NUM_CH*CH_W-1:0]   frame_q, frame_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     last_slot;
    logic                     accept;
    logic                     take;
    logic [CH_W-1:0]          word_sel;

    assign last_slot = (cnt_q == CNT_W'(NUM_SLOTS - 1));
    assign accept    = in_valid && in_ready;
    assign take      = out_valid && out_ready;

    mux8_word #(.CH_W(CH_W)) u_mux8_word (
        .sel   (cnt_q[SEL_W-1:0]),
        .words (frame_q),
        .word  (word_sel)
    );

`ifdef TDM_PARITY_EN
    logic [CH_W-1:0] parity_word;

    always_comb begin
        parity_word = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            parity_word = parity_word ^ frame_q[i*CH_W +: CH_W];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            frame_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    frame_d = in_data;
                    cnt_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (take) begin
                    if (last_slot) begin
                        cnt_d = '0;
                        // a frame accepted on the final beat continues without a bubble
                        if (accept) frame_d = in_data;
                        else        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_sel   = '0;
        out_sof   = 1'b0;
        out_par   = 1'b0;
        case (state_q)
            ST_IDLE: in_ready = 1'b1;
            ST_SEND: begin
                out_valid = 1'b1;
                in_ready  = last_slot && out_ready;
                out_data  = word_sel;
                out_sel   = cnt_q[SEL_W-1:0];
                out_sof   = (cnt_q == '0);
`ifdef TDM_PARITY_EN
                if (cnt_q == CNT_W'(NUM_CH)) begin
                    out_data = parity_word;
                    out_sel  = SEL_W'(NUM_CH - 1);
                    out_par  = 1'b1;
                end
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tdm_mux8.sv
// Self-checking bench for tdm_mux8: directed scenarios then random traffic,
// compared against a queue-of-expected-slots reference model.
module tb_tdm_mux8;
    import tdm_mux8_pkg::*;

    localparam int CH_W = 8;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NUM_CH*CH_W-1:0] in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [CH_W-1:0]        out_data;
    logic [SEL_W-1:0]       out_sel;
    logic                   out_sof;
    logic                   out_par;
    logic                   out_valid;
    logic                   out_ready;

    tdm_mux8 #(.CH_W(CH_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_sof   (out_sof),
        .out_par   (out_par),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CH_W-1:0]  data;
        logic [SEL_W-1:0] sel;
        logic             sof;
        logic             par;
    } slot_t;

    slot_t q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    logic  acc;
    logic  tk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NUM_CH*CH_W-1:0] mk_frame(input int base);
        logic [NUM_CH*CH_W-1:0] f;
        for (int k = 0; k < NUM_CH; k++) f[k*CH_W +: CH_W] = CH_W'(base + k);
        return f;
    endfunction

    // Each accepted frame becomes a list of slots in emission order.
    function automatic void push_frame(input logic [NUM_CH*CH_W-1:0] f);
        slot_t s;
        logic [CH_W-1:0] x;
        x = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            s.data = f[k*CH_W +: CH_W];
            s.sel  = SEL_W'(k);
            s.sof  = (k == 0);
            s.par  = 1'b0;
            x      = x ^ s.data;
            q.push_back(s);
        end
        if (NUM_SLOTS > NUM_CH) begin
            s.data = x;
            s.sel  = SEL_W'(NUM_CH - 1);
            s.sof  = 1'b0;
            s.par  = 1'b1;
            q.push_back(s);
        end
    endfunction

    // Check outputs mid-cycle, then advance the model across one rising edge.
    task automatic tick();
        logic exp_valid;
        logic exp_rdy;
        #1;
        exp_valid = (q.size() != 0);
        exp_rdy   = (q.size() == 0) || (q.size() == 1 && out_ready);
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        chk("in_ready",  32'(in_ready),  32'(exp_rdy));
        if (exp_valid) begin
            chk("out_data", 32'(out_data), 32'(q[0].data));
            chk("out_sel",  32'(out_sel),  32'(q[0].sel));
            chk("out_sof",  32'(out_sof),  32'(q[0].sof));
            chk("out_par",  32'(out_par),  32'(q[0].par));
        end
        acc = in_valid && exp_rdy;
        tk  = exp_valid && out_ready;
        @(posedge clk);
        if (tk)  void'(q.pop_front());
        if (acc) push_frame(in_data);
        @(negedge clk);
    endtask

    task automatic load(input logic [NUM_CH*CH_W-1:0] f);
        in_data  = f;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) tick();
        chk("drain_timeout", q.size(), 0);
        tick();
    endtask

    task automatic wait_sel(input int n);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (q.size() != 0 && q[0].sel == SEL_W'(n) && !q[0].par) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("wait_sel_timeout", 32'(found), 1);
    endtask

    task automatic wait_last();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (q.size() == 1) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("wait_last_timeout", 32'(found), 1);
    endtask

    initial begin
        int nacc;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready",  32'(in_ready),  1);
        chk("rst_out_data",  32'(out_data),  0);
        chk("rst_out_sel",   32'(out_sel),   0);
        chk("rst_out_sof",   32'(out_sof),   0);
        chk("rst_out_par",   32'(out_par),   0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // single frame, free-flowing output
        load(mk_frame(8'h10));
        drain();

        // back-to-back frames A then B with in_valid held
        nacc     = 0;
        in_data  = mk_frame(8'hA0);
        in_valid = 1'b1;
        for (int i = 0; i < 40 && nacc < 2; i++) begin
            tick();
            if (acc) begin
                nacc++;
                in_data = mk_frame(8'hB0);
            end
        end
        chk("b2b_accepts", nacc, 2);
        in_valid = 1'b0;
        drain();

        // backpressure for three cycles on slot 4
        load(mk_frame(8'h20));
        wait_sel(4);
        out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
        drain();

        // stall on the last slot while a new frame is pending
        load(mk_frame(8'h30));
        wait_last();
        in_data   = mk_frame(8'h40);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        drain();

        // asynchronous reset in the middle of a frame
        load(mk_frame(8'h50));
        wait_sel(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_in_ready",  32'(in_ready),  1);
        chk("midrst_out_sel",   32'(out_sel),   0);
        chk("midrst_out_data",  32'(out_data),  0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        load(mk_frame(8'h60));
        drain();

        // one-hot frame (parity word 0xFF when the parity slot exists)
        begin
            logic [NUM_CH*CH_W-1:0] f;
            for (int k = 0; k < NUM_CH; k++) f[k*CH_W +: CH_W] = CH_W'(1 << k);
            load(f);
        end
        drain();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            in_data   = {$urandom, $urandom};
            in_valid  = ($urandom_range(0, 2) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
